// File: rtl/winograd_pkg.sv
// rtl/winograd_pkg.sv - shared constants, loader state encoding and tiling helper for the Winograd F(4x4,3x3) datapath.
package winograd_pkg;

    localparam int TILE       = 6;
    localparam int STEP       = 4;
    localparam int WORD_W     = 16;
    localparam int TILE_WORDS = TILE * TILE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_HOLD
    } loader_state_e;

    function automatic int tiles_per_dim(input int img, input int pad);
        return (img + 2 * pad - TILE) / STEP + 1;
    endfunction

endpackage

// File: rtl/act_tile_addr_gen.sv
// rtl/act_tile_addr_gen.sv - word/tile counters with registered read address and pad flag for the tile loader.
module act_tile_addr_gen
    import winograd_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10,
    parameter int PAD    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              clear,
    input  logic              step,
    input  logic              next_tile,
    input  logic [ADDR_W-1:0] act_base,
    output logic [ADDR_W-1:0] addr,
    output logic              word_pad,
    output logic [2:0]        tile_x,
    output logic [2:0]        tile_y,
    output logic              last_word,
    output logic              last_tile
);

    localparam int NX = tiles_per_dim(IMG_W, PAD);
    localparam int NY = tiles_per_dim(IMG_H, PAD);
    localparam logic [2:0] TILE_LAST = 3'(TILE - 1);
    localparam logic [2:0] NX_LAST   = 3'(NX - 1);
    localparam logic [2:0] NY_LAST   = 3'(NY - 1);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        r_q, r_d, c_q, c_d;
    logic [2:0]        tx_q, tx_d, ty_q, ty_d;
    logic              pad_q, pad_d;
    int                row, col;

    // Address and pad flag are computed from the next counter values so that
    // both are registered and line up with the word the counters point at.
    always_comb begin
        base_d = base_q;
        r_d    = r_q;
        c_d    = c_q;
        tx_d   = tx_q;
        ty_d   = ty_q;
        if (init) begin
            base_d = act_base;
            r_d    = 3'd0;
            c_d    = 3'd0;
            tx_d   = 3'd0;
            ty_d   = 3'd0;
        end else if (clear) begin
            r_d  = 3'd0;
            c_d  = 3'd0;
            tx_d = 3'd0;
            ty_d = 3'd0;
        end else if (step) begin
            if (c_q == TILE_LAST) begin
                c_d = 3'd0;
                r_d = (r_q == TILE_LAST) ? 3'd0 : r_q + 3'd1;
            end else begin
                c_d = c_q + 3'd1;
            end
        end else if (next_tile) begin
            if (tx_q == NX_LAST) begin
                tx_d = 3'd0;
                ty_d = (ty_q == NY_LAST) ? 3'd0 : ty_q + 3'd1;
            end else begin
                tx_d = tx_q + 3'd1;
            end
        end

        row    = int'(ty_d) * STEP + int'(r_d) - PAD;
        col    = int'(tx_d) * STEP + int'(c_d) - PAD;
        addr_d = base_d + ADDR_W'(row * IMG_W + col);
        pad_d  = (row < 0) || (row >= IMG_H) || (col < 0) || (col >= IMG_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            addr_q <= '0;
            r_q    <= 3'd0;
            c_q    <= 3'd0;
            tx_q   <= 3'd0;
            ty_q   <= 3'd0;
            pad_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            addr_q <= addr_d;
            r_q    <= r_d;
            c_q    <= c_d;
            tx_q   <= tx_d;
            ty_q   <= ty_d;
            pad_q  <= pad_d;
        end
    end

    assign addr      = addr_q;
    assign word_pad  = pad_q;
    assign tile_x    = tx_q;
    assign tile_y    = ty_q;
    assign last_word = (r_q == TILE_LAST) && (c_q == TILE_LAST);
    assign last_tile = (tx_q == NX_LAST) && (ty_q == NY_LAST);

endmodule

// File: rtl/act_tile_loader.sv
// rtl/act_tile_loader.sv - 6x6 activation tile loader FSM and tile handshake; ACT_ZERO_PAD_EN adds a 1-word zero border and pad_zero.
module act_tile_loader
    import winograd_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] act_base,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              shift_en,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [2:0]        tile_x,
    output logic [2:0]        tile_y,
    output logic              last_tile,
    output logic              busy,
`ifdef ACT_ZERO_PAD_EN
    output logic              pad_zero,
`endif
    output logic              done
);

`ifdef ACT_ZERO_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    loader_state_e state_q, state_d;
    logic shift_en_q, shift_en_d;
    logic tile_valid_q, tile_valid_d;
    logic last_tile_q, last_tile_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic init, clear, step, next_tile;
    logic word_pad, last_word, tile_last;

    act_tile_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .PAD   (PAD)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (init),
        .clear    (clear),
        .step     (step),
        .next_tile(next_tile),
        .act_base (act_base),
        .addr     (mem_rd_addr),
        .word_pad (word_pad),
        .tile_x   (tile_x),
        .tile_y   (tile_y),
        .last_word(last_word),
        .last_tile(tile_last)
    );

    always_comb begin
        state_d   = state_q;
        init      = 1'b0;
        clear     = 1'b0;
        step      = 1'b0;
        next_tile = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    init    = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                step = 1'b1;
                if (last_word) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (tile_ready) begin
                    next_tile = 1'b1;
                    if (tile_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // abort wins over everything, including a handshake in the same cycle
        if (abort) begin
            state_d   = ST_IDLE;
            clear     = 1'b1;
            init      = 1'b0;
            step      = 1'b0;
            next_tile = 1'b0;
            done_d    = 1'b0;
        end

        shift_en_d   = (state_d == ST_LOAD);
        tile_valid_d = (state_d == ST_HOLD);
        last_tile_d  = (state_d == ST_HOLD) && tile_last;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_en_q   <= 1'b0;
            tile_valid_q <= 1'b0;
            last_tile_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_en_q   <= shift_en_d;
            tile_valid_q <= tile_valid_d;
            last_tile_q  <= last_tile_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef ACT_ZERO_PAD_EN
    logic pad_zero_q, pad_zero_d;

    // Delayed one cycle so it lines up with the read data of the same word.
    always_comb begin
        pad_zero_d = shift_en_q & word_pad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_zero_q <= 1'b0;
        end else begin
            pad_zero_q <= pad_zero_d;
        end
    end

    assign pad_zero = pad_zero_q;
`endif

    assign mem_rd_en  = shift_en_q & ~word_pad;
    assign shift_en   = shift_en_q;
    assign tile_valid = tile_valid_q;
    assign last_tile  = last_tile_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_act_tile_loader.sv
// tb/tb_act_tile_loader.sv - scoreboard bench for act_tile_loader; also covers the ACT_ZERO_PAD_EN build.
module tb_act_tile_loader;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 10;
`ifdef ACT_ZERO_PAD_EN
    localparam int PAD = 1;
    localparam int EXP_PAD_WORDS = 11;
`else
    localparam int PAD = 0;
    localparam int EXP_PAD_WORDS = 0;
`endif
    localparam int NX = (IMG_W + 2 * PAD - 6) / 4 + 1;
    localparam int NY = (IMG_H + 2 * PAD - 6) / 4 + 1;
    localparam int NT = NX * NY;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] act_base;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              shift_en;
    logic              tile_valid;
    logic              tile_ready;
    logic [2:0]        tile_x;
    logic [2:0]        tile_y;
    logic              last_tile;
    logic              busy;
    logic              done;
`ifdef ACT_ZERO_PAD_EN
    logic              pad_zero;
`endif

    act_tile_loader #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .act_base   (act_base),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .shift_en   (shift_en),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .last_tile  (last_tile),
        .busy       (busy),
`ifdef ACT_ZERO_PAD_EN
        .pad_zero   (pad_zero),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rd;
    } word_t;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       last;
    } tile_t;

    word_t exp_words[$];
    tile_t exp_tiles[$];
    int vec_cnt  = 0;
    int err_cnt  = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input logic [ADDR_W-1:0] base, input int tx, input int ty, input int nwords);
        word_t w;
        int r, c, row, col;
        for (int k = 0; k < nwords; k++) begin
            r      = k / 6;
            c      = k % 6;
            row    = ty * 4 + r - PAD;
            col    = tx * 4 + c - PAD;
            w.addr = base + ADDR_W'(row * IMG_W + col);
            w.rd   = !((row < 0) || (row >= IMG_H) || (col < 0) || (col >= IMG_W));
            exp_words.push_back(w);
        end
    endtask

    task automatic push_map(input logic [ADDR_W-1:0] base);
        tile_t t;
        for (int ty = 0; ty < NY; ty++) begin
            for (int tx = 0; tx < NX; tx++) begin
                push_tile(base, tx, ty, 36);
                t.x    = 3'(tx);
                t.y    = 3'(ty);
                t.last = (tx == NX - 1) && (ty == NY - 1);
                exp_tiles.push_back(t);
            end
        end
    endtask

    task automatic wait_done(input int bound);
        int  base_cnt;
        logic ok;
        base_cnt = done_cnt;
        ok       = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            ok = (done_cnt != base_cnt);
        end
        chk("done_seen", 32'(ok), 1);
        chk("busy_after_done", 32'(busy), 0);
        repeat (3) tick();
        chk("done_single_pulse", 32'(done_cnt - base_cnt), 1);
    endtask

    task automatic wait_valid(input int bound);
        logic found;
        found = tile_valid;
        for (int i = 0; i < bound && !found; i++) begin
            tick();
            found = tile_valid;
        end
        chk("hold_reached", 32'(found), 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a word or a handshake.
`ifdef ACT_ZERO_PAD_EN
    logic pend_pad = 1'b0;
`endif
    always @(negedge clk) begin
        word_t w;
        tile_t t;
        logic  cur_pad;
        cur_pad = 1'b0;
        if (shift_en) begin
            chk("word_expected", 32'(exp_words.size() != 0), 1);
            if (exp_words.size() != 0) begin
                w = exp_words.pop_front();
                chk("rd_addr", 32'(mem_rd_addr), 32'(w.addr));
                chk("rd_en", 32'(mem_rd_en), 32'(w.rd));
                cur_pad = !w.rd;
            end
        end else if (mem_rd_en) begin
            chk("rd_en_without_shift", 32'(mem_rd_en), 0);
        end
`ifdef ACT_ZERO_PAD_EN
        chk("pad_zero", 32'(pad_zero), 32'(pend_pad));
        pend_pad = cur_pad;
`endif
        if (tile_valid && shift_en) begin
            chk("valid_shift_overlap", 32'(shift_en), 0);
        end
        if (tile_valid && tile_ready) begin
            hs_cnt++;
            chk("tile_expected", 32'(exp_tiles.size() != 0), 1);
            if (exp_tiles.size() != 0) begin
                t = exp_tiles.pop_front();
                chk("tile_x", 32'(tile_x), 32'(t.x));
                chk("tile_y", 32'(tile_y), 32'(t.y));
                chk("last_tile", 32'(last_tile), 32'(t.last));
            end
        end
        if (done) begin
            done_cnt++;
            chk("busy_with_done", 32'(busy), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pad_cnt;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        tile_ready = 1'b0;
        act_base   = '0;
        repeat (3) tick();
        chk("rst_tile_valid", 32'(tile_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_shift_en", 32'(shift_en), 0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        chk("rst_addr", 32'(mem_rd_addr), 0);
        chk("rst_tile_xy", 32'({tile_x, tile_y}), 0);
        chk("rst_last_tile", 32'(last_tile), 0);
        rst_n = 1'b1;
        tick();

        // Map 1: base 0x100, directed timing on the first tile, then a stalled HOLD.
        hs_cnt   = 0;
        done_cnt = 0;
        push_map(10'h100);
        act_base   = 10'h100;
        tile_ready = 1'b1;
        start      = 1'b1;
        tick();
        start    = 1'b0;
        act_base = 10'h000;
        pad_cnt  = 0;
        for (int cyc = 1; cyc <= 39; cyc++) begin
            if (cyc <= 36 && shift_en && !mem_rd_en) pad_cnt++;
`ifdef ACT_ZERO_PAD_EN
            if (cyc == 1) begin
                chk("c1_addr", 32'(mem_rd_addr), 32'h0DF);
                chk("c1_rd_en", 32'(mem_rd_en), 0);
            end
            if (cyc == 8) begin
                chk("c8_addr", 32'(mem_rd_addr), 32'h100);
                chk("c8_rd_en", 32'(mem_rd_en), 1);
            end
            if (cyc == 36) chk("c36_addr", 32'(mem_rd_addr), 32'h184);
`else
            if (cyc <= 6) chk("row0_addr", 32'(mem_rd_addr), 32'h100 + 32'(cyc - 1));
            if (cyc == 7) chk("row1_addr", 32'(mem_rd_addr), 32'h120);
            if (cyc == 36) chk("c36_addr", 32'(mem_rd_addr), 32'h1A5);
`endif
            if (cyc == 1) chk("c1_shift_en", 32'(shift_en), 1);
            if (cyc == 36) chk("c36_shift_en", 32'(shift_en), 1);
            if (cyc == 37) begin
                chk("flush_valid", 32'(tile_valid), 0);
                chk("flush_shift", 32'(shift_en), 0);
            end
            if (cyc == 38) begin
                chk("c38_valid", 32'(tile_valid), 1);
                chk("c38_shift", 32'(shift_en), 0);
            end
            if (cyc == 39) begin
                chk("c39_shift", 32'(shift_en), 1);
                chk("c39_tile_x", 32'(tile_x), 1);
                tile_ready = 1'b0;
            end
            if (cyc < 39) tick();
        end
        chk("tile0_pad_words", 32'(pad_cnt), 32'(EXP_PAD_WORDS));

        wait_valid(60);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(tile_valid), 1);
            chk("stall_shift", 32'(shift_en), 0);
            if (i == 3) begin
                start    = 1'b1;
                act_base = 10'h2AA;
            end
            if (i == 4) start = 1'b0;
            tick();
        end
        tile_ready = 1'b1;
        tick();
        chk("resume_shift", 32'(shift_en), 1);
        chk("resume_valid", 32'(tile_valid), 0);
        chk("resume_tile_x", 32'(tile_x), 2);
        wait_done(NT * 40 + 200);
        chk("map1_handshakes", 32'(hs_cnt), 32'(NT));
        chk("map1_words_left", 32'(exp_words.size()), 0);
        chk("map1_tiles_left", 32'(exp_tiles.size()), 0);

        // Abort in LOAD cycle 20.
        push_tile(10'h040, 0, 0, 20);
        act_base = 10'h040;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_shift", 32'(shift_en), 0);
        chk("abort_rd_en", 32'(mem_rd_en), 0);
        chk("abort_valid", 32'(tile_valid), 0);
        chk("abort_words_left", 32'(exp_words.size()), 0);
        tick();

        // Restart after abort with a base that wraps the address space.
        hs_cnt   = 0;
        done_cnt = 0;
        push_map(10'h3F0);
        act_base = 10'h3F0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_tile_xy", 32'({tile_x, tile_y}), 0);
        chk("restart_shift", 32'(shift_en), 1);
        wait_done(NT * 40 + 200);
        chk("map2_handshakes", 32'(hs_cnt), 32'(NT));
        chk("map2_words_left", 32'(exp_words.size()), 0);
        chk("map2_tiles_left", 32'(exp_tiles.size()), 0);

        // Asynchronous reset while holding a tile.
        tile_ready = 1'b0;
        push_tile(10'h000, 0, 0, 36);
        act_base = 10'h000;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(60);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(tile_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_shift", 32'(shift_en), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_words_left", 32'(exp_words.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
